// File: rtl/multiplication_unit_if.sv
// Issue-queue and CDB signal bundle for the multiplication unit.
// The master modport is the queue/arbiter side; the slave modport is the unit.
interface multiplication_unit_if #(
  parameter int TAG_W = 5
);
  logic             issueque_ready;
  logic [31:0]      issueque_rs_data;
  logic [31:0]      issueque_rt_data;
  logic [TAG_W-1:0] issueque_rd_tag;
  logic             issueblk_issue;
  logic             cdb_req;
  logic             cdb_grant;
  logic             mult_cdb_valid;
  logic [TAG_W-1:0] mult_cdb_tag;
  logic [31:0]      mult_cdb_lo;
  logic [31:0]      mult_cdb_hi;
  logic             mult_busy;
  logic             flush_valid;

  modport master (
    output issueque_ready, issueque_rs_data, issueque_rt_data, issueque_rd_tag,
    output cdb_grant, flush_valid,
    input  issueblk_issue, cdb_req, mult_cdb_valid, mult_cdb_tag,
    input  mult_cdb_lo, mult_cdb_hi, mult_busy
  );

  modport slave (
    input  issueque_ready, issueque_rs_data, issueque_rt_data, issueque_rd_tag,
    input  cdb_grant, flush_valid,
    output issueblk_issue, cdb_req, mult_cdb_valid, mult_cdb_tag,
    output mult_cdb_lo, mult_cdb_hi, mult_busy
  );
endinterface

// File: rtl/multiplication_unit.sv
// Pipelined 32x32 -> 64 multiply unit between the issue queue and the CDB.
// Define MULT_SIGNED_EN for two's-complement operands; default build is unsigned.
module multiplication_unit #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 5
) (
  input logic                  clock,
  input logic                  nreset,
  multiplication_unit_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;

  function automatic logic [PROD_W-1:0] mul_full(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef MULT_SIGNED_EN
    logic signed [PROD_W-1:0] sa;
    logic signed [PROD_W-1:0] sb;
    sa = {{DATA_W{a[DATA_W-1]}}, a};
    sb = {{DATA_W{b[DATA_W-1]}}, b};
    return PROD_W'(sa * sb);
`else
    return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
  endfunction

  logic [LATENCY-1:0] vld_p;
  logic [TAG_W-1:0]   tag_p [LATENCY];
  logic [DATA_W-1:0]  rs_p0;
  logic [DATA_W-1:0]  rt_p0;
  logic [PROD_W-1:0]  prod_p [1:LATENCY-1];

  logic advance;
  logic issue;
  logic cdb_fire;

  // The whole pipe moves together: the final stage is empty or is being broadcast.
  assign advance  = !vld_p[LATENCY-1] | bus.cdb_grant;
  assign issue    = nreset & bus.issueque_ready & advance & !bus.flush_valid;
  assign cdb_fire = vld_p[LATENCY-1] & bus.cdb_grant & !bus.flush_valid;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      vld_p <= '0;
      rs_p0 <= '0;
      rt_p0 <= '0;
      for (int i = 0; i < LATENCY; i++) tag_p[i] <= '0;
      for (int i = 1; i < LATENCY; i++) prod_p[i] <= '0;
    end else begin
      if (bus.flush_valid)
        vld_p <= '0;
      else if (advance)
        vld_p <= {vld_p[LATENCY-2:0], issue};

      if (advance) begin
        // Stage 0: operand capture
        rs_p0    <= bus.issueque_rs_data;
        rt_p0    <= bus.issueque_rt_data;
        tag_p[0] <= bus.issueque_rd_tag;
        // Stage 1: full product
        prod_p[1] <= mul_full(rs_p0, rt_p0);
        tag_p[1]  <= tag_p[0];
        // Stages 2..LATENCY-1: delay to the requested latency
        for (int i = 2; i < LATENCY; i++) begin
          prod_p[i] <= prod_p[i-1];
          tag_p[i]  <= tag_p[i-1];
        end
      end
    end
  end

  assign bus.issueblk_issue = issue;
  assign bus.cdb_req        = vld_p[LATENCY-1];
  assign bus.mult_cdb_valid = cdb_fire;
  assign bus.mult_cdb_tag   = cdb_fire ? tag_p[LATENCY-1] : '0;
  assign bus.mult_cdb_lo    = cdb_fire ? prod_p[LATENCY-1][DATA_W-1:0] : '0;
  assign bus.mult_cdb_hi    = cdb_fire ? prod_p[LATENCY-1][PROD_W-1:DATA_W] : '0;
  assign bus.mult_busy      = |vld_p;
endmodule

// File: doc/multiplication_unit.md
Name: multiplication_unit

Overview:
- Pipelined 32x32 multiply execution unit on the consumer side of the multiplication issue queue.
- Takes ready entries from the queue through the issue handshake (`issueque_ready` / `issueblk_issue`) and carries the destination tag through a fixed-depth pipeline.
- Requests the common data bus (CDB) and broadcasts the 64-bit product and tag on grant.
- Stalls the whole pipeline under CDB back-pressure and clears on ROB flush.

Parameters:
- LATENCY, 4, number of pipeline stages (legal range 2..8); issue-to-CDB-request latency in cycles.
- TAG_W, 5, destination tag width.

Ports:
- clock  input  1  rising-edge clock
- nreset  input  1  asynchronous active-low reset
- issueque_ready  input  1  queue holds at least one ready entry
- issueque_rs_data  input  32  operand A of the selected entry
- issueque_rt_data  input  32  operand B of the selected entry
- issueque_rd_tag  input  TAG_W  destination tag of the selected entry
- issueblk_issue  output  1  entry accepted this cycle; queue removes it at the next edge
- cdb_req  output  1  result waiting in the final stage
- cdb_grant  input  1  CDB arbiter grant for this unit
- mult_cdb_valid  output  1  broadcast valid
- mult_cdb_tag  output  TAG_W  broadcast tag
- mult_cdb_lo  output  32  product bits 31:0
- mult_cdb_hi  output  32  product bits 63:32
- mult_busy  output  1  at least one stage valid
- flush_valid  input  1  ROB flush, synchronous

Behaviour:
- Reset: asynchronous, nreset low clears all stage valid bits, tags and data. All outputs are 0 while reset is asserted and after it releases.
- Pipeline structure:
  - Stages 0..LATENCY-1, each holding valid, tag and partial/final product.
  - The product may be split across stages in any way. Stage LATENCY-1 must hold the complete product.
- Advance condition: `advance = !stage[L-1].valid | cdb_grant`.
  - When advance=1, every stage shifts one position and stage 0 loads the issued entry, or a bubble if nothing issued.
  - When advance=0, all stages hold their contents.
- Issue:
  - `issueblk_issue = issueque_ready & advance & !flush_valid`, combinational.
  - Operands and tag are sampled in the same cycle `issueblk_issue`=1.
- Latency: an op issued in cycle N sits in stage L-1 in cycle N+LATENCY, with `cdb_req`=1, provided no stall occurred.
- Throughput: 1 op per cycle while `cdb_grant` keeps up.
- CDB handshake:
  - `cdb_req = stage[L-1].valid`.
  - `mult_cdb_valid = stage[L-1].valid & cdb_grant & !flush_valid`.
  - `mult_cdb_tag`, `mult_cdb_lo` and `mult_cdb_hi` are driven from stage L-1 whenever `mult_cdb_valid`=1, and are 0 otherwise.
  - A request, once raised, stays high with stable tag and data until granted.
  - `cdb_grant` while `cdb_req`=0 is ignored.
- Bubbles: bubbles do not compress under stall; the pipeline stalls as a whole.
- Arithmetic: full 64-bit product of rs*rt, unsigned by default (see Optional Feature). No overflow flag.
- Flush:
  - `flush_valid`=1 clears every stage valid bit at the next edge.
  - `issueblk_issue` and `mult_cdb_valid` are forced 0 in that cycle.
  - Flush has priority over grant and issue.
- Busy: `mult_busy` is the OR of all stage valid bits.
- Simultaneous grant and issue in the same cycle: the final-stage result broadcasts, and the new op enters stage 0 in the same edge.
- Reset mid-operation: all in-flight ops are discarded and no broadcast occurs.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- When defined, operands are two's-complement signed and `mult_cdb_hi` is the signed upper product.
- When undefined, operands are unsigned.
- `mult_cdb_lo` is identical in both builds.

Test Plan:
- Basic latency: after reset, `cdb_grant` tied 1; issue rs=7, rt=6, tag=3 in cycle 0 → `cdb_req`=1 and `mult_cdb_valid`=1 in cycle 4 with lo=42, hi=0, tag=3.
- Back-to-back: 4 consecutive issues (rs=1..4, rt=10, tags 1..4), grant tied 1 → broadcasts in cycles 4..7 of 10, 20, 30, 40 in order; `issueblk_issue` high every cycle.
- Back-pressure:
  - Setup: issue tag=5 (rs=3, rt=3); hold `cdb_grant`=0 for 3 cycles after `cdb_req` rises, with `issueque_ready`=1 and tags 6 and 7 issued before the stall.
  - Expected during stall: `issueblk_issue`=0 while stalled; tag 5, data 9 held stable.
  - Expected on grant: tag 5 broadcasts first, then tags 6 and 7 follow on consecutive cycles.
- Flush: issue 3 ops, assert `flush_valid` for 1 cycle at cycle 2 → no `mult_cdb_valid` ever; `mult_busy`=0 from cycle 3; a new issue in cycle 3 broadcasts at cycle 7.
- Wide operands: rs=0xFFFFFFFF, rt=2:
  - Unsigned build: lo=0xFFFFFFFE, hi=0x00000001.
  - MULT_SIGNED_EN build: lo=0xFFFFFFFE, hi=0xFFFFFFFF.
- Reset mid-flight: deassert nreset with 2 ops in the pipe → all outputs 0 immediately; no broadcast after release.
